// File: rtl/crc_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions for the transmit framer and receive checker.
package crc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CRC_W  = 16;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        CRC_HI = 2'd1,
        CRC_LO = 2'd2
    } state_t;

    // Eight MSB-first shift steps of polynomial 0x1021 folded into one byte update.
    function automatic logic [CRC_W-1:0] crc16_ccitt_byte(input logic [CRC_W-1:0] crc,
                                                          input logic [DATA_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[CRC_W-1] ? (CRC_W'(c << 1) ^ CRC16_POLY) : CRC_W'(c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_frame_appender.sv
// Passes payload bytes through and appends the frame's CRC-16 (high byte, then low byte with last).
module crc16_frame_appender
    import crc_pkg::*;
#(
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter logic [15:0] CRC_XOROUT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] crc_value,
    output logic        crc_done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CRC_W-1:0]    r_crc;
    logic [CRC_W-1:0]    w_crc_next;
    logic [CRC_W-1:0]    w_crc_final;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_last;
    logic [CRC_W-1:0]    r_crc_value;
    logic                r_crc_done;
    logic                w_slot_free;
    logic                w_s_ready;
    logic                w_load;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_load_last;
    logic                w_crc_done;

    assign w_slot_free = !r_m_valid || m_ready;
    assign w_crc_final = r_crc ^ CRC_XOROUT;

    // State and running CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PASS;
            r_crc   <= CRC_INIT;
        end else begin
            r_state <= w_state_next;
            r_crc   <= w_crc_next;
        end
    end

    // Next state, output-slot load request and CRC update.
    always_comb begin
        w_state_next = r_state;
        w_crc_next   = r_crc;
        w_s_ready    = 1'b0;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_last  = 1'b0;
        w_crc_done   = 1'b0;
        unique case (r_state)
            PASS: begin
                w_s_ready = w_slot_free;
                if (s_valid && w_s_ready) begin
                    w_load      = 1'b1;
                    w_load_data = s_data;
                    w_crc_next  = crc16_ccitt_byte(r_crc, s_data);
                    if (s_last) begin
                        w_state_next = CRC_HI;
                    end
                end
            end
            CRC_HI: begin
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_data  = w_crc_final[15:8];
                    w_state_next = CRC_LO;
                end
            end
            CRC_LO: begin
                if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_load_data  = w_crc_final[7:0];
                    w_load_last  = 1'b1;
                    w_crc_done   = 1'b1;
                    w_crc_next   = CRC_INIT;
                    w_state_next = PASS;
                end
            end
            default: begin
                w_state_next = PASS;
            end
        endcase
    end

    // Output register: reloads or empties only when downstream frees the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_slot_free) begin
            r_m_valid <= w_load;
            if (w_load) begin
                r_m_data <= w_load_data;
                r_m_last <= w_load_last;
            end
        end
    end

    // Completed-frame CRC report and its one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc_value <= '0;
            r_crc_done  <= 1'b0;
        end else begin
            r_crc_done <= w_crc_done;
            if (w_crc_done) begin
                r_crc_value <= w_crc_final;
            end
        end
    end

    assign s_ready   = w_s_ready && !reset;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_last    = r_m_last;
    assign crc_value = r_crc_value;
    assign crc_done  = r_crc_done;

endmodule

// File: tb/tb_crc16_frame_appender.sv
// Directed bench for crc16_frame_appender: table of frames plus back-to-back and reset sequences.
module tb_crc16_frame_appender;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_ready;
    logic        s_ready0, s_readyx;
    logic        m_valid0, m_validx;
    logic [7:0]  m_data0, m_datax;
    logic        m_last0, m_lastx;
    logic [15:0] crc_value0, crc_valuex;
    logic        crc_done0, crc_donex;

    crc16_frame_appender #(.CRC_INIT(16'hFFFF), .CRC_XOROUT(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
        .crc_value(crc_value0), .crc_done(crc_done0)
    );

    crc16_frame_appender #(.CRC_INIT(16'hFFFF), .CRC_XOROUT(16'hFFFF)) dut_x (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_readyx), .s_data(s_data), .s_last(s_last),
        .m_valid(m_validx), .m_ready(m_ready), .m_data(m_datax), .m_last(m_lastx),
        .crc_value(crc_valuex), .crc_done(crc_donex)
    );

    typedef struct {
        string       name;
        int          len;
        logic [7:0]  b[9];
        logic [15:0] crc;
        logic [15:0] crc_x;
        bit          rnd;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    bit          rnd_mode = 0;
    bit          count_en = 0;
    int          low_cnt = 0;
    int          done0 = 0;
    int          donex = 0;
    logic [8:0]  q0[$];
    logic [8:0]  qx[$];
    logic [15:0] crcq0[$];
    logic [15:0] crcqx[$];
    logic [9:0]  prev0;
    bit          stall0 = 0;
    vec_t        vecs[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: constant 1 or a coin flip per cycle.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output transfer capture, CRC strobe capture, stall-hold check.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid0 && m_ready) q0.push_back({m_last0, m_data0});
            if (m_validx && m_ready) qx.push_back({m_lastx, m_datax});
            if (crc_done0) begin
                done0++;
                crcq0.push_back(crc_value0);
                chk("done_with_last", 32'(m_last0), 32'd1);
            end
            if (crc_donex) begin
                donex++;
                crcqx.push_back(crc_valuex);
            end
            if (stall0) chk("stall_hold", 32'({m_valid0, m_last0, m_data0}), 32'(prev0));
            stall0 = m_valid0 && !m_ready;
            prev0  = {m_valid0, m_last0, m_data0};
            if (count_en && s_valid && !s_ready0) low_cnt++;
        end else begin
            stall0 = 0;
        end
    end

    task automatic clear_logs();
        q0.delete(); qx.delete(); crcq0.delete(); crcqx.delete();
        done0 = 0; donex = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0; acc = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input vec_t v, input bit hold);
        for (int i = 0; i < v.len; i++) send_byte(v.b[i], i == v.len - 1);
        if (!hold) begin
            s_valid = 1'b0; s_last = 1'b0;
        end
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (q0.size() < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk("out_count", 32'(q0.size()), 32'(n));
        chk("out_count_x", 32'(qx.size()), 32'(n));
    endtask

    task automatic check_frame(input vec_t v);
        logic [8:0] e, ex;
        logic [9:0] a, ax;
        for (int i = 0; i < v.len + 2; i++) begin
            if (i < v.len) begin
                e = {1'b0, v.b[i]}; ex = e;
            end else if (i == v.len) begin
                e = {1'b0, v.crc[15:8]}; ex = {1'b0, v.crc_x[15:8]};
            end else begin
                e = {1'b1, v.crc[7:0]}; ex = {1'b1, v.crc_x[7:0]};
            end
            a  = (i < q0.size()) ? {1'b0, q0[i]} : 10'h3FF;
            ax = (i < qx.size()) ? {1'b0, qx[i]} : 10'h3FF;
            chk({v.name, "_byte"}, 32'(a), 32'({1'b0, e}));
            chk({v.name, "_byte_x"}, 32'(ax), 32'({1'b0, ex}));
        end
        chk({v.name, "_done_cnt"}, 32'(done0), 32'd1);
        chk({v.name, "_done_cnt_x"}, 32'(donex), 32'd1);
        chk({v.name, "_crc_value"}, 32'(crc_value0), 32'(v.crc));
        chk({v.name, "_crc_value_x"}, 32'(crc_valuex), 32'(v.crc_x));
    endtask

    initial begin
        int nlast;
        reset = 1'b1; s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;

        vecs[0] = '{name: "str9", len: 9,
                    b: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39},
                    crc: 16'h29B1, crc_x: 16'hD64E, rnd: 0};
        vecs[1] = '{name: "one00", len: 1, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    crc: 16'hE1F0, crc_x: 16'h1E0F, rnd: 0};
        vecs[2] = '{name: "oneFF", len: 1, b: '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    crc: 16'hFF00, crc_x: 16'h00FF, rnd: 0};
        vecs[3] = '{name: "twoFF", len: 2, b: '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    crc: 16'h0000, crc_x: 16'hFFFF, rnd: 0};
        vecs[4] = vecs[0];
        vecs[4].name = "str9_bp";
        vecs[4].rnd  = 1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid0), 32'd0);
        chk("rst_m_data", 32'(m_data0), 32'd0);
        chk("rst_m_last", 32'(m_last0), 32'd0);
        chk("rst_s_ready", 32'(s_ready0), 32'd0);
        chk("rst_crc_value", 32'(crc_value0), 32'd0);
        chk("rst_crc_done", 32'(crc_done0), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; s_valid = 1'b0;
        @(posedge clk);
        #1;

        // Table of frames.
        for (int k = 0; k < 5; k++) begin
            rnd_mode = vecs[k].rnd;
            clear_logs();
            send_frame(vecs[k], 0);
            wait_out(vecs[k].len + 2);
            check_frame(vecs[k]);
            rnd_mode = 0;
            @(posedge clk);
            #1;
        end

        // Back-to-back frames with s_valid held high across the boundary.
        clear_logs();
        low_cnt = 0;
        count_en = 1;
        send_frame(vecs[0], 1);
        send_frame(vecs[1], 0);
        wait_out(14);
        count_en = 0;
        chk("b2b_ready_low", 32'(low_cnt), 32'd2);
        chk("b2b_done_cnt", 32'(done0), 32'd2);
        chk("b2b_crc0", 32'(crcq0.size() > 0 ? crcq0[0] : 16'hDEAD), 32'h29B1);
        chk("b2b_crc1", 32'(crcq0.size() > 1 ? crcq0[1] : 16'hDEAD), 32'hE1F0);
        chk("b2b_last0", 32'(q0.size() > 10 ? q0[10] : 9'h0), 32'h1B1);
        chk("b2b_next0", 32'(q0.size() > 11 ? q0[11] : 9'h1FF), 32'h000);
        chk("b2b_last1", 32'(q0.size() > 13 ? q0[13] : 9'h0), 32'h1F0);
        chk("b2b_crcx1", 32'(crcqx.size() > 1 ? crcqx[1] : 16'hDEAD), 32'h1E0F);
        @(posedge clk);
        #1;

        // Reset in the middle of a frame, then the full frame again.
        clear_logs();
        for (int i = 0; i < 4; i++) send_byte(vecs[0].b[i], 1'b0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_m_valid", 32'(m_valid0), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready0), 32'd0);
        chk("mid_rst_m_last", 32'(m_last0), 32'd0);
        nlast = 0;
        foreach (q0[i]) if (q0[i][8]) nlast++;
        chk("mid_rst_no_last", 32'(nlast), 32'd0);
        chk("mid_rst_partial", 32'(q0.size()), 32'd4);
        chk("mid_rst_no_done", 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        send_frame(vecs[0], 0);
        wait_out(11);
        check_frame(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a bounded wait is defeated somehow.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/crc16_frame_appender.md
# crc16_frame_appender

Byte-stream framer that sits in front of the CCITT CRC datapath. It passes each frame's payload bytes through unchanged and computes CRC-16/CCITT-FALSE over them on the fly. It then appends the two CRC bytes, high byte first, and marks the low CRC byte as the end of frame. Upstream is the payload source; downstream is the serializer/line-coding stage.

## Interface
- CRC_INIT, 16'hFFFF, CRC register value at reset and at the start of every frame.
- CRC_XOROUT, 16'h0000, value XORed into the final CRC before it is appended and reported.
- clk  in  1  clock; every register samples on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  block accepts s_data this cycle.
- s_data  in  8  payload byte.
- s_last  in  1  s_data is the final payload byte of the frame.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts m_data this cycle.
- m_data  out  8  payload byte or appended CRC byte.
- m_last  out  1  m_data is the low CRC byte, which ends the frame.
- crc_value  out  16  final CRC of the most recently completed frame; holds until the next frame completes.
- crc_done  out  1  one-cycle pulse when crc_value updates.

## Operation
- Handshakes:
  - A transfer on s occurs when s_valid && s_ready.
  - A transfer on m occurs when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable.
- Output slot:
  - The output register is free when !m_valid || m_ready.
- CRC definition:
  - Polynomial 0x1021, MSB-first.
  - Byte-parallel update: crc_next = f(crc, byte), computing 8 serial steps in one cycle.
  - There is no input or output reflection.
- The FSM has three states: PASS, CRC_HI, CRC_LO. The reset state is PASS.
- PASS:
  - s_ready = slot free.
  - On each s transfer: m_data <= s_data, m_last <= 0, m_valid <= 1, crc <= f(crc, s_data).
  - If s_last is set on that transfer, go to CRC_HI.
- CRC_HI:
  - s_ready = 0.
  - When the slot is free: m_data <= (crc ^ CRC_XOROUT)[15:8], m_last <= 0, m_valid <= 1; go to CRC_LO.
- CRC_LO:
  - s_ready = 0.
  - When the slot is free:
    - m_data <= (crc ^ CRC_XOROUT)[7:0], m_last <= 1, m_valid <= 1.
    - crc_value <= crc ^ CRC_XOROUT, crc_done <= 1.
    - crc <= CRC_INIT; go to PASS.
- In PASS and CRC_HI, if the slot is free and no byte is loaded, m_valid <= 0.
- Frame length:
  - A frame of N ≥ 1 payload bytes produces N+2 output bytes.
  - Zero-length frames cannot exist, because s_last always accompanies a byte.
- Reset:
  - m_valid=0, m_data=0, m_last=0, s_ready=0 during reset.
  - crc=CRC_INIT, crc_value=0, crc_done=0, state=PASS.
- Reset mid-frame discards the partial frame and any pending CRC byte. No m_last is emitted for that frame.

## Timing
- Payload latency is 1 cycle: a byte accepted in cycle t appears on m_data in cycle t+1.
- With m_ready held at 1, the sequence after the last payload byte is:
  - Last byte accepted at t.
  - CRC high byte valid at t+2.
  - CRC low byte valid at t+3.
  - s_ready low at t+1 and t+2.
  - s_ready high again at t+3.
  - First byte of the next frame may be accepted at t+3 and is valid on m at t+4.
- Throughput is one byte per cycle during payload, plus two bubble-free CRC cycles per frame.
- crc_done pulses in the cycle after the CRC_LO load, i.e. the same cycle m_last first goes high. crc_value is valid from that cycle.
- Backpressure:
  - Deasserting m_ready stalls the FSM and CRC state with no loss or duplication.
  - s_ready follows combinationally from m_ready and the state.

## Structure
- Package crc_pkg holds:
  - CRC16_POLY = 16'h1021.
  - The state enum {PASS, CRC_HI, CRC_LO}.
  - The function crc16_ccitt_byte(crc[15:0], data[7:0]) returning the next 16-bit CRC.
- The function lives in the package so that the CRC checker on the receive side can reuse it.
- No sub-module: the block is a single FSM plus the output register.

## Test plan
- Frame "123456789" (0x31..0x39, s_last on 0x39), m_ready=1 -> 11 output bytes: the payload, then 0x29, then 0xB1 with m_last=1; crc_value=0x29B1; crc_done high for exactly 1 cycle.
- Single-byte frame 0x00 -> output 0x00, 0xE1, 0xF0 (m_last on 0xF0); crc_value=0xE1F0.
- "123456789" with m_ready driven by a random pattern at 50% -> the output byte sequence is identical to the first scenario; m_data never changes while m_valid && !m_ready.
- Two back-to-back frames "123456789" then 0x00, s_valid held at 1 -> s_ready low for exactly 2 cycles between frames; CRCs are 0x29B1 then 0xE1F0, proving the CRC re-initialises between frames.
- Reset asserted after the 4th byte of "123456789", then the full frame resent -> no m_last before reset; after reset only the clean 11-byte frame appears with CRC 0x29B1.
- CRC_XOROUT=16'hFFFF, frame "123456789" -> appended bytes 0xD6, 0x4E; crc_value=0xD64E.
